// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: forwarding-select codes, shadow-entry
// metadata and the default register address width.
package cpu_pkg;

    localparam int REG_AW_DEF = 5;

    // EX operand source selects
    localparam logic [1:0] FWD_RF = 2'd0;  // value captured in DC/EX
    localparam logic [1:0] FWD_MA = 2'd1;  // alu_out_ma
    localparam logic [1:0] FWD_WB = 2'd2;  // wdata in WB

    // Per-stage destination metadata; the register address is appended by
    // the user so its width can follow the instance's REG_AW.
    typedef struct packed {
        logic valid;
        logic we;
        logic is_load;
    } shadow_meta_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles with i_inc high, sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // Increment unless already at the ceiling.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding controller for the IF/DC/EX/MA/WB pipeline.
// A shadow copy of destination metadata for EX, MA and WB is compared
// against the DC sources to drive stall/bubble/flush, EX-aligned forward
// selects and the regfile write-through override.
//
// Handshake note: DC "advances" into EX on a clock edge when dc_valid is
// high, no stall is raised and no redirect is in progress; only an advancing
// instruction is recorded in the EX shadow entry, otherwise EX gets a bubble.
module pipe_hazard_unit
    import cpu_pkg::*;
#(
    parameter int REG_AW   = REG_AW_DEF,
    parameter bit ZERO_REG = 1'b1,
    parameter bit FWD_EN   = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              dc_valid,
    input  logic [REG_AW-1:0] dc_rs1,
    input  logic [REG_AW-1:0] dc_rs2,
    input  logic              dc_rs1_used,
    input  logic              dc_rs2_used,
    input  logic [REG_AW-1:0] dc_rd,
    input  logic              dc_we,
    input  logic              dc_is_load,
    input  logic              ex_redirect,
    output logic              stall_if_dc,
    output logic              bubble_ex,
    output logic              flush_if_dc,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              dcex_rs1_from_wb,
    output logic              dcex_rs2_from_wb,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef struct packed {
        shadow_meta_t      meta;
        logic [REG_AW-1:0] rd;
    } shadow_e_t;

    shadow_e_t  r_ex_e, r_ma_e, r_wb_e;
    logic [1:0] r_fwd_a_sel, r_fwd_b_sel;

    shadow_e_t  w_dc_e;
    logic       w_ex_m1, w_ex_m2, w_ma_m1, w_ma_m2, w_wb_m1, w_wb_m2;
    logic       w_hazard, w_stall, w_advance;
    logic [1:0] w_sel_a, w_sel_b;
    logic       w_unused_meta;

    // A producer in stage e feeds source r of the DC instruction.
    function automatic logic f_match(shadow_e_t e, logic [REG_AW-1:0] r, logic used);
        return e.meta.valid && e.meta.we && (e.rd == r) && used
               && !(ZERO_REG && (r == '0));
    endfunction

    // Youngest producer wins; a load in EX has no result yet (that case stalls).
    function automatic logic [1:0] f_sel(logic m_ex, logic m_ma, logic ex_is_load);
        if (m_ex && !ex_is_load) return FWD_MA;
        else if (m_ma)           return FWD_WB;
        else                     return FWD_RF;
    endfunction

    // Source/producer matches, hazard detection and DC advance decision.
    always_comb begin
        w_ex_m1 = f_match(r_ex_e, dc_rs1, dc_rs1_used);
        w_ex_m2 = f_match(r_ex_e, dc_rs2, dc_rs2_used);
        w_ma_m1 = f_match(r_ma_e, dc_rs1, dc_rs1_used);
        w_ma_m2 = f_match(r_ma_e, dc_rs2, dc_rs2_used);
        w_wb_m1 = f_match(r_wb_e, dc_rs1, dc_rs1_used);
        w_wb_m2 = f_match(r_wb_e, dc_rs2, dc_rs2_used);
        if (FWD_EN) begin
            w_hazard = (w_ex_m1 || w_ex_m2) && r_ex_e.meta.is_load;
        end else begin
            w_hazard = w_ex_m1 || w_ex_m2 || w_ma_m1 || w_ma_m2 || w_wb_m1 || w_wb_m2;
        end
        // Redirect wins: a stalled instruction on the wrong path is discarded.
        w_stall   = w_hazard && dc_valid && !ex_redirect;
        w_advance = dc_valid && !w_stall && !ex_redirect;
        w_sel_a   = f_sel(w_ex_m1, w_ma_m1, r_ex_e.meta.is_load);
        w_sel_b   = f_sel(w_ex_m2, w_ma_m2, r_ex_e.meta.is_load);

        w_dc_e              = '0;
        w_dc_e.meta.valid   = 1'b1;
        w_dc_e.meta.we      = dc_we;
        w_dc_e.meta.is_load = dc_is_load;
        w_dc_e.rd           = dc_rd;
    end

    // Load flags only matter while the producer is in EX.
    assign w_unused_meta = r_ma_e.meta.is_load ^ r_wb_e.meta.is_load;

    // Shadow pipeline shift; EX takes the DC instruction or a bubble.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ex_e <= '0;
            r_ma_e <= '0;
            r_wb_e <= '0;
        end else begin
            r_wb_e <= r_ma_e;
            r_ma_e <= r_ex_e;
            r_ex_e <= w_advance ? w_dc_e : '0;
        end
    end

    // Forward selects travel with the instruction into EX; bubbles get 0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_fwd_a_sel <= FWD_RF;
            r_fwd_b_sel <= FWD_RF;
        end else if (FWD_EN && w_advance) begin
            r_fwd_a_sel <= w_sel_a;
            r_fwd_b_sel <= w_sel_b;
        end else begin
            r_fwd_a_sel <= FWD_RF;
            r_fwd_b_sel <= FWD_RF;
        end
    end

    assign stall_if_dc      = w_stall;
    assign bubble_ex        = w_stall || ex_redirect;
    assign flush_if_dc      = ex_redirect;
    assign fwd_a_sel        = r_fwd_a_sel;
    assign fwd_b_sel        = r_fwd_b_sel;
    // The regfile has no write-through, so a WB producer overrides the read.
    assign dcex_rs1_from_wb = w_wb_m1 && dc_valid;
    assign dcex_rs2_from_wb = w_wb_m2 && dc_valid;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .resetn  (resetn),
        .i_inc   (w_stall),
        .o_count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .resetn  (resetn),
        .i_inc   (ex_redirect),
        .o_count (flush_cnt)
    );

endmodule
